// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encodings
// (also consumed by debug/trace), per-cycle control pattern and decoded control word.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MDU_WAIT = 2'd2,
        MEM_WAIT = 2'd3
    } stallState_t;

    typedef enum logic [2:0] {
        PAT_NORMAL = 3'd0,
        PAT_MEMFRZ = 3'd1,
        PAT_MDUFRZ = 3'd2,
        PAT_LDSTL  = 3'd3,
        PAT_FLUSH  = 3'd4
    } stallPat_t;

    typedef struct packed {
        logic pcWr;
        logic ifidWr;
        logic ifidFlush;
        logic idexWr;
        logic idexBubble;
        logic exmemWr;
        logic exmemBubble;
        logic memwbBubble;
    } pipeCtrl_t;

    function automatic pipeCtrl_t patToCtrl(input stallPat_t pat);
        pipeCtrl_t c;
        c.pcWr        = 1'b1;
        c.ifidWr      = 1'b1;
        c.ifidFlush   = 1'b0;
        c.idexWr      = 1'b1;
        c.idexBubble  = 1'b0;
        c.exmemWr     = 1'b1;
        c.exmemBubble = 1'b0;
        c.memwbBubble = 1'b0;
        case (pat)
            PAT_MEMFRZ: begin
                c.pcWr        = 1'b0;
                c.ifidWr      = 1'b0;
                c.idexWr      = 1'b0;
                c.exmemWr     = 1'b0;
                c.memwbBubble = 1'b1;
            end
            PAT_MDUFRZ: begin
                c.pcWr        = 1'b0;
                c.ifidWr      = 1'b0;
                c.idexWr      = 1'b0;
                c.exmemBubble = 1'b1;
            end
            PAT_LDSTL: begin
                c.pcWr       = 1'b0;
                c.ifidWr     = 1'b0;
                c.idexBubble = 1'b1;
            end
            PAT_FLUSH: begin
                c.ifidFlush  = 1'b1;
                c.idexBubble = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset; holds at all-ones instead of wrapping.
// Latency: q reflects inc one clock later. Backpressure: none, inc is sampled every cycle.
// Reset has priority over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer merging load-use, branch redirect, MDU busy and memory wait.
// Latency: pipeline controls are combinational (same-cycle stall); stall_cnt/timeout_err registered.
// Backpressure: a memory wait freezes every stage and wins over all other stall sources.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int LOAD_LAT    = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_load_use,
    input  logic             ex_branch_tkn,
    input  logic             ex_mdu_start,
    input  logic             mdu_done,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_wr,
    output logic             ifid_wr,
    output logic             ifid_flush,
    output logic             idex_wr,
    output logic             idex_bubble,
    output logic             exmem_wr,
    output logic             exmem_bubble,
    output logic             memwb_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             timeout_err
);

    localparam int LD_W = (LOAD_LAT > 2) ? $clog2(LOAD_LAT) : 1;

    stallState_t state, nextState;
    stallPat_t   pattern;
    pipeCtrl_t   ctrl;
    logic [LD_W-1:0] ldCnt, ldCntNext;
    logic [TO_W-1:0] toCnt;
    logic memStall;
    logic mduBusy;

    assign memStall = mem_req & ~mem_ready;
    assign mduBusy  = ex_mdu_start & ~mdu_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            ldCnt <= '0;
        end else begin
            state <= nextState;
            ldCnt <= ldCntNext;
        end
    end

    // In MDU_WAIT the RUN decode is only reached with mdu_done=1, where mduBusy
    // is already 0, so the shared decode naturally drops the MDU term.
    always_comb begin
        nextState = state;
        ldCntNext = ldCnt;
        pattern   = PAT_NORMAL;
        if (memStall) begin
            pattern = PAT_MEMFRZ;
            if (state == RUN) begin
                nextState = MEM_WAIT;
            end
        end else if (state == MDU_WAIT && !mdu_done) begin
            pattern = PAT_MDUFRZ;
        end else if (state == LD_STALL) begin
            pattern   = PAT_LDSTL;
            ldCntNext = ldCnt - LD_W'(1);
            if (ldCnt == LD_W'(1)) begin
                nextState = RUN;
            end
        end else begin
            nextState = RUN;
            if (mduBusy) begin
                pattern   = PAT_MDUFRZ;
                nextState = MDU_WAIT;
            end else if (ex_branch_tkn) begin
                pattern = PAT_FLUSH;
            end else if (id_load_use) begin
                pattern = PAT_LDSTL;
                if (LOAD_LAT > 1) begin
                    nextState = LD_STALL;
                    ldCntNext = LD_W'(LOAD_LAT - 1);
                end
            end
        end
    end

    always_comb begin
        ctrl = rst ? '0 : patToCtrl(pattern);
    end

    assign pc_wr        = ctrl.pcWr;
    assign ifid_wr      = ctrl.ifidWr;
    assign ifid_flush   = ctrl.ifidFlush;
    assign idex_wr      = ctrl.idexWr;
    assign idex_bubble  = ctrl.idexBubble;
    assign exmem_wr     = ctrl.exmemWr;
    assign exmem_bubble = ctrl.exmemBubble;
    assign memwb_bubble = ctrl.memwbBubble;

    // Timeout only flags the condition; the freeze itself is left untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            toCnt       <= '0;
            timeout_err <= 1'b0;
        end else if (pattern == PAT_MEMFRZ) begin
            if (toCnt != '1) begin
                toCnt <= toCnt + TO_W'(1);
            end
            if (toCnt == TO_W'(MEM_TIMEOUT - 1)) begin
                timeout_err <= 1'b1;
            end
        end else begin
            toCnt <= '0;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) uStallCnt (
        .clk(clk),
        .rst(rst),
        .inc(~ctrl.pcWr),
        .q  (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: instance A uses defaults, instance B uses
// LOAD_LAT=3, MEM_TIMEOUT=4, CNT_W=3; both share the same stimulus.
module tb_pipe_stall_ctrl;

    // Control word order: pc_wr, ifid_wr, ifid_flush, idex_wr, idex_bubble, exmem_wr, exmem_bubble, memwb_bubble
    localparam logic [7:0] P_RST    = 8'b0000_0000;
    localparam logic [7:0] P_NORMAL = 8'b1101_0100;
    localparam logic [7:0] P_MEMFRZ = 8'b0000_0001;
    localparam logic [7:0] P_MDUFRZ = 8'b0000_0110;
    localparam logic [7:0] P_LDSTL  = 8'b0001_1100;
    localparam logic [7:0] P_FLUSH  = 8'b1111_1100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic idLoadUse = 1'b0, exBranchTkn = 1'b0, exMduStart = 1'b0;
    logic mduDone = 1'b0, memReq = 1'b0, memReady = 1'b0;

    logic [7:0]  ctlA, ctlB;
    logic [31:0] stallA;
    logic [2:0]  stallB;
    logic        toErrA, toErrB;

    int vectors = 0;
    int miscompares = 0;

    pipe_stall_ctrl dutA (
        .clk(clk), .rst(rst),
        .id_load_use(idLoadUse), .ex_branch_tkn(exBranchTkn), .ex_mdu_start(exMduStart),
        .mdu_done(mduDone), .mem_req(memReq), .mem_ready(memReady),
        .pc_wr(ctlA[7]), .ifid_wr(ctlA[6]), .ifid_flush(ctlA[5]), .idex_wr(ctlA[4]),
        .idex_bubble(ctlA[3]), .exmem_wr(ctlA[2]), .exmem_bubble(ctlA[1]), .memwb_bubble(ctlA[0]),
        .stall_cnt(stallA), .timeout_err(toErrA)
    );

    pipe_stall_ctrl #(
        .LOAD_LAT(3), .MEM_TIMEOUT(4), .TO_W(8), .CNT_W(3)
    ) dutB (
        .clk(clk), .rst(rst),
        .id_load_use(idLoadUse), .ex_branch_tkn(exBranchTkn), .ex_mdu_start(exMduStart),
        .mdu_done(mduDone), .mem_req(memReq), .mem_ready(memReady),
        .pc_wr(ctlB[7]), .ifid_wr(ctlB[6]), .ifid_flush(ctlB[5]), .idex_wr(ctlB[4]),
        .idex_bubble(ctlB[3]), .exmem_wr(ctlB[2]), .exmem_bubble(ctlB[1]), .memwb_bubble(ctlB[0]),
        .stall_cnt(stallB), .timeout_err(toErrB)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consume one rising edge, then drive the inputs for the new cycle and let them settle.
    task automatic apply(input logic r, input logic lu, input logic br, input logic ms,
                         input logic md, input logic mq, input logic mrdy);
        @(posedge clk);
        #1;
        rst = r; idLoadUse = lu; exBranchTkn = br; exMduStart = ms;
        mduDone = md; memReq = mq; memReady = mrdy;
        #1;
    endtask

    initial begin
        // Reset state
        apply(1, 0, 0, 0, 0, 0, 0);
        chk("rst_ctlA", 32'(ctlA), 32'(P_RST));
        chk("rst_ctlB", 32'(ctlB), 32'(P_RST));
        chk("rst_stallA", stallA, 32'd0);
        chk("rst_stallB", 32'(stallB), 32'd0);
        chk("rst_toErrA", 32'(toErrA), 32'd0);
        chk("rst_toErrB", 32'(toErrB), 32'd0);

        // Load-use pulse: A stalls once, B stalls three cycles
        apply(0, 1, 0, 0, 0, 0, 0);
        chk("ld_c0_A", 32'(ctlA), 32'(P_LDSTL));
        chk("ld_c0_B", 32'(ctlB), 32'(P_LDSTL));
        apply(0, 0, 0, 0, 0, 0, 0);
        chk("ld_c1_A", 32'(ctlA), 32'(P_NORMAL));
        chk("ld_c1_B", 32'(ctlB), 32'(P_LDSTL));
        chk("ld_stallA", stallA, 32'd1);
        apply(0, 0, 0, 0, 0, 0, 0);
        chk("ld_c2_B", 32'(ctlB), 32'(P_LDSTL));
        apply(0, 0, 0, 0, 0, 0, 0);
        chk("ld_c3_B", 32'(ctlB), 32'(P_NORMAL));
        chk("ld_stallB", 32'(stallB), 32'd3);

        // Branch wins over load-use: flush only
        apply(0, 1, 1, 0, 0, 0, 0);
        chk("br_A", 32'(ctlA), 32'(P_FLUSH));
        chk("br_B", 32'(ctlB), 32'(P_FLUSH));
        apply(0, 0, 0, 0, 0, 0, 0);
        chk("br_next_A", 32'(ctlA), 32'(P_NORMAL));
        chk("br_next_B", 32'(ctlB), 32'(P_NORMAL));
        chk("br_stallA", stallA, 32'd1);
        chk("br_stallB", 32'(stallB), 32'd3);

        // Memory wait interrupting a multi-cycle load stall holds its count
        apply(0, 1, 0, 0, 0, 0, 0);
        chk("ldm_c0_B", 32'(ctlB), 32'(P_LDSTL));
        apply(0, 0, 0, 0, 0, 1, 0);
        chk("ldm_frz1_A", 32'(ctlA), 32'(P_MEMFRZ));
        chk("ldm_frz1_B", 32'(ctlB), 32'(P_MEMFRZ));
        apply(0, 0, 0, 0, 0, 1, 0);
        chk("ldm_frz2_B", 32'(ctlB), 32'(P_MEMFRZ));
        apply(0, 0, 0, 0, 0, 0, 0);
        chk("ldm_rel_A", 32'(ctlA), 32'(P_NORMAL));
        chk("ldm_rel_B", 32'(ctlB), 32'(P_LDSTL));
        apply(0, 0, 0, 0, 0, 0, 0);
        chk("ldm_last_B", 32'(ctlB), 32'(P_LDSTL));
        apply(0, 0, 0, 0, 0, 0, 0);
        chk("ldm_done_B", 32'(ctlB), 32'(P_NORMAL));
        chk("ldm_stallA", stallA, 32'd4);
        chk("ldm_stallB_sat", 32'(stallB), 32'd7);

        // MDU occupancy: five frozen cycles, then normal on done
        apply(1, 0, 0, 0, 0, 0, 0);
        chk("mdu_rst_A", 32'(ctlA), 32'(P_RST));
        apply(0, 0, 0, 1, 0, 0, 0);
        chk("mdu_stallA0", stallA, 32'd0);
        chk("mdu_stallB0", 32'(stallB), 32'd0);
        chk("mdu_c1_A", 32'(ctlA), 32'(P_MDUFRZ));
        for (int i = 2; i <= 5; i++) begin
            apply(0, 0, 0, 1, 0, 0, 0);
            chk("mdu_frz_A", 32'(ctlA), 32'(P_MDUFRZ));
            chk("mdu_frz_B", 32'(ctlB), 32'(P_MDUFRZ));
        end
        apply(0, 0, 0, 1, 1, 0, 0);
        chk("mdu_done_A", 32'(ctlA), 32'(P_NORMAL));
        chk("mdu_done_B", 32'(ctlB), 32'(P_NORMAL));
        chk("mdu_stallA", stallA, 32'd5);
        chk("mdu_stallB", 32'(stallB), 32'd5);
        apply(0, 0, 0, 0, 0, 0, 0);
        chk("mdu_after_B", 32'(ctlB), 32'(P_NORMAL));

        // Saturation to 9 stalls, then reset in the middle of MDU_WAIT
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 0, 1, 0, 0, 0);
        end
        chk("sat_ctlB", 32'(ctlB), 32'(P_MDUFRZ));
        chk("sat_stallA", stallA, 32'd9);
        chk("sat_stallB", 32'(stallB), 32'd7);
        apply(1, 0, 0, 1, 0, 0, 0);
        chk("midrst_A", 32'(ctlA), 32'(P_RST));
        chk("midrst_B", 32'(ctlB), 32'(P_RST));
        apply(0, 0, 0, 0, 0, 0, 0);
        chk("postrst_A", 32'(ctlA), 32'(P_NORMAL));
        chk("postrst_B", 32'(ctlB), 32'(P_NORMAL));
        chk("postrst_stallA", stallA, 32'd0);
        chk("postrst_stallB", 32'(stallB), 32'd0);

        // Memory timeout: memory stall overrides branch and load-use
        apply(0, 1, 1, 0, 0, 1, 0);
        chk("to_frz1_A", 32'(ctlA), 32'(P_MEMFRZ));
        chk("to_frz1_B", 32'(ctlB), 32'(P_MEMFRZ));
        for (int i = 2; i <= 4; i++) begin
            apply(0, 1, 1, 0, 0, 1, 0);
            chk("to_frz_B", 32'(ctlB), 32'(P_MEMFRZ));
            chk("to_early_B", 32'(toErrB), 32'd0);
        end
        apply(0, 1, 1, 0, 0, 1, 0);
        chk("to_set_B", 32'(toErrB), 32'd1);
        chk("to_still_frz_B", 32'(ctlB), 32'(P_MEMFRZ));
        chk("to_none_A", 32'(toErrA), 32'd0);
        apply(0, 0, 0, 0, 0, 1, 0);
        chk("to_hold_B", 32'(toErrB), 32'd1);
        apply(0, 0, 0, 0, 0, 1, 1);
        chk("to_ready_A", 32'(ctlA), 32'(P_NORMAL));
        chk("to_ready_B", 32'(ctlB), 32'(P_NORMAL));
        apply(0, 0, 0, 0, 0, 0, 0);
        chk("to_sticky_B", 32'(toErrB), 32'd1);
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0);
        chk("to_clr_B", 32'(toErrB), 32'd0);
        chk("to_clr_ctlB", 32'(ctlB), 32'(P_NORMAL));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
